// File: rtl/wb_evict_buffer.sv
// Write-back eviction buffer: absorbs dirty victim lines in one cycle, drains them
// to main memory in FIFO order, and serves FILL lookups from still-buffered lines.
module wb_evict_buffer #(
   parameter int DEPTH  = 4,
   parameter int LINE_W = 256,
   parameter int ADDR_W = 26
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enq_valid,
   output logic                   enq_ready,
   input  logic [ADDR_W-1:0]      enq_addr,
   input  logic [LINE_W-1:0]      enq_data,
   output logic                   mm_wr,
   output logic [ADDR_W-1:0]      mm_wr_addr,
   output logic [LINE_W-1:0]      mm_wr_data,
   input  logic                   mm_ack,
   input  logic [ADDR_W-1:0]      lk_addr,
   output logic                   lk_hit,
   output logic [LINE_W-1:0]      lk_data,
   input  logic                   flush,
   output logic                   flush_done,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);
   // state | meaning
   // IDLE  | no request outstanding; one bubble cycle between writes
   // ISSUE | head entry presented on mm_wr until mm_ack
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, ISSUE} state_t;
   state_t state, state_nxt;

   logic [DEPTH-1:0]  valid;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [LINE_W-1:0] data_q [DEPTH];
   logic [PW-1:0]     wp, rp;
   logic              flush_pend;

   logic              enq_fire, retire, coal_hit, pend_nxt, done_nxt;
   logic [PW-1:0]     coal_idx, idx_c, idx_l;
   logic [CW-1:0]     count_nxt;

   assign full       = (count == CW'(DEPTH));
   assign empty      = (count == '0);
   assign enq_ready  = !full;
   assign enq_fire   = enq_valid && enq_ready;
   assign retire     = (state == ISSUE) && mm_ack;
   assign mm_wr      = (state == ISSUE);
   assign mm_wr_addr = addr_q[rp];
   assign mm_wr_data = data_q[rp];

   // The head in ISSUE must stay stable on the bus, so it never absorbs a coalesce.
   always_comb begin
      coal_hit = 1'b0;
      coal_idx = '0;
      idx_c    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx_c = rp + PW'(k);
         if (valid[idx_c] && addr_q[idx_c] == enq_addr && !(state == ISSUE && k == 0)) begin
            coal_hit = 1'b1;
            coal_idx = idx_c;
         end
      end
   end

   // Scan oldest to newest so the newest match wins.
   always_comb begin
      lk_hit  = 1'b0;
      lk_data = '0;
      idx_l   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx_l = rp + PW'(k);
         if (valid[idx_l] && addr_q[idx_l] == lk_addr) begin
            lk_hit  = 1'b1;
            lk_data = data_q[idx_l];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!empty) state_nxt = ISSUE;
         ISSUE:   if (mm_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign count_nxt = count + CW'(enq_fire && !coal_hit) - CW'(retire);
   assign pend_nxt  = flush_pend || flush;
   assign done_nxt  = pend_nxt && (count_nxt == '0) && (state_nxt == IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wp         <= '0;
         rp         <= '0;
         count      <= '0;
         valid      <= '0;
         flush_pend <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         flush_done <= done_nxt;
         flush_pend <= pend_nxt && !done_nxt;
         if (enq_fire && !coal_hit) begin
            valid[wp] <= 1'b1;
            wp        <= wp + PW'(1);
         end
         if (retire) begin
            valid[rp] <= 1'b0;
            rp        <= rp + PW'(1);
         end
      end
   end

   // Line storage is qualified by valid, so it needs no reset.
   always_ff @(posedge clk) begin
      if (enq_fire) begin
         if (coal_hit) begin
            data_q[coal_idx] <= enq_data;
         end else begin
            addr_q[wp] <= enq_addr;
            data_q[wp] <= enq_data;
         end
      end
   end
endmodule

// File: tb/tb_wb_evict_buffer.sv
// Bench for wb_evict_buffer: cycle table for the basic paths, a reference queue model
// checked every cycle, and hand sequences for coalescing, wrap, flush and reset.
module tb_wb_evict_buffer;
   localparam int DEPTH  = 4;
   localparam int LINE_W = 256;
   localparam int ADDR_W = 26;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              enq_valid = 1'b0;
   logic              enq_ready;
   logic [ADDR_W-1:0] enq_addr = '0;
   logic [LINE_W-1:0] enq_data = '0;
   logic              mm_wr;
   logic [ADDR_W-1:0] mm_wr_addr;
   logic [LINE_W-1:0] mm_wr_data;
   logic              mm_ack = 1'b0;
   logic [ADDR_W-1:0] lk_addr = '0;
   logic              lk_hit;
   logic [LINE_W-1:0] lk_data;
   logic              flush = 1'b0;
   logic              flush_done;
   logic [CW-1:0]     count;
   logic              empty, full;

   wb_evict_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr), .enq_data(enq_data),
      .mm_wr(mm_wr), .mm_wr_addr(mm_wr_addr), .mm_wr_data(mm_wr_data), .mm_ack(mm_ack),
      .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
      .flush(flush), .flush_done(flush_done),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic [7:0] tag);
      return {8{tag, 6'h0, a[17:0]}};
   endfunction

   // Reference model: expected queue contents in FIFO order.
   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] data;
   } ent_t;
   ent_t q[$];
   ent_t tmp;
   bit   m_live = 1'b0, m_issue = 1'b0, m_pend = 1'b0, m_done = 1'b0;
   bit   ack_m, pend_n, m_hit;
   int   sz0, hit;
   logic [LINE_W-1:0] m_lk;
   logic [LINE_W-1:0] mm0 [logic [ADDR_W-1:0]];
   int   wr_cnt = 0;

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         m_issue = 1'b0;
         m_pend  = 1'b0;
         m_done  = 1'b0;
         m_live  = 1'b1;
      end else if (m_live) begin
         sz0   = q.size();
         ack_m = m_issue && mm_ack;
         if (enq_valid && sz0 < DEPTH) begin
            hit = -1;
            for (int i = sz0 - 1; i >= 0; i--)
               if (hit < 0 && q[i].addr == enq_addr && !(i == 0 && m_issue)) hit = i;
            if (hit >= 0) q[hit].data = enq_data;
            else q.push_back(ent_t'{addr: enq_addr, data: enq_data});
         end
         if (ack_m) begin
            tmp = q.pop_front();
            m_issue = 1'b0;
         end else if (!m_issue && sz0 != 0) begin
            m_issue = 1'b1;
         end
         pend_n = m_pend || flush;
         m_done = pend_n && q.size() == 0 && !m_issue;
         m_pend = pend_n && !m_done;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("count", LINE_W'(count), LINE_W'(q.size()));
         chk("full", LINE_W'(full), LINE_W'(q.size() == DEPTH));
         chk("empty", LINE_W'(empty), LINE_W'(q.size() == 0));
         chk("enq_ready", LINE_W'(enq_ready), LINE_W'(q.size() != DEPTH));
         chk("mm_wr", LINE_W'(mm_wr), LINE_W'(m_issue));
         if (m_issue) begin
            chk("wr_addr", LINE_W'(mm_wr_addr), LINE_W'(q[0].addr));
            chk("wr_data", mm_wr_data, q[0].data);
         end
         chk("flush_done", LINE_W'(flush_done), LINE_W'(m_done));
         m_hit = 1'b0;
         m_lk  = '0;
         foreach (q[i]) if (q[i].addr == lk_addr) begin
            m_hit = 1'b1;
            m_lk  = q[i].data;
         end
         chk("lk_hit", LINE_W'(lk_hit), LINE_W'(m_hit));
         chk("lk_data", lk_data, m_lk);
         if (!reset && mm_wr && mm_ack) begin
            mm0[mm_wr_addr] = mm_wr_data;
            wr_cnt++;
         end
      end
   end

   typedef struct {
      logic              ev;
      logic [ADDR_W-1:0] ea;
      logic [LINE_W-1:0] ed;
      logic              ack;
      logic [CW-1:0]     cnt;
      logic              wr;
   } vec_t;

   function automatic vec_t mk(input logic ev, input logic [ADDR_W-1:0] ea, input logic ack,
                               input logic [CW-1:0] cnt, input logic wr);
      vec_t v;
      v.ev  = ev;
      v.ea  = ea;
      v.ed  = (ea == 26'h10) ? {32{8'hA5}} : pat(ea, 8'hB0);
      v.ack = ack;
      v.cnt = cnt;
      v.wr  = wr;
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
      enq_valid = 1'b1;
      enq_addr  = a;
      enq_data  = d;
      cyc();
      enq_valid = 1'b0;
   endtask

   task automatic wait_wr(input string name);
      int n = 0;
      while (!mm_wr && n < 20) begin
         cyc();
         n++;
      end
      chk(name, LINE_W'(mm_wr), LINE_W'(1));
   endtask

   task automatic drain(input string name);
      int n = 0;
      mm_ack = 1'b1;
      while (!(empty && !mm_wr) && n < 40) begin
         cyc();
         n++;
      end
      mm_ack = 1'b0;
      chk(name, LINE_W'(empty), LINE_W'(1));
   endtask

   localparam int NV = 17;
   vec_t tbl[NV];
   int   base, acks, dones, ack3, done_at;

   initial begin
      // Single line with ack tied high, then fill/ordering with ack low.
      tbl[0]  = mk(1'b1, 26'h10, 1'b1, 3'd0, 1'b0);
      tbl[1]  = mk(1'b0, 26'h0,  1'b1, 3'd1, 1'b0);
      tbl[2]  = mk(1'b0, 26'h0,  1'b1, 3'd1, 1'b1);
      tbl[3]  = mk(1'b0, 26'h0,  1'b0, 3'd0, 1'b0);
      tbl[4]  = mk(1'b1, 26'h0,  1'b0, 3'd0, 1'b0);
      tbl[5]  = mk(1'b1, 26'h1,  1'b0, 3'd1, 1'b0);
      tbl[6]  = mk(1'b1, 26'h2,  1'b0, 3'd2, 1'b1);
      tbl[7]  = mk(1'b1, 26'h3,  1'b0, 3'd3, 1'b1);
      tbl[8]  = mk(1'b1, 26'h4,  1'b0, 3'd4, 1'b1);
      tbl[9]  = mk(1'b0, 26'h0,  1'b1, 3'd4, 1'b1);
      tbl[10] = mk(1'b0, 26'h0,  1'b1, 3'd3, 1'b0);
      tbl[11] = mk(1'b0, 26'h0,  1'b1, 3'd3, 1'b1);
      tbl[12] = mk(1'b0, 26'h0,  1'b1, 3'd2, 1'b0);
      tbl[13] = mk(1'b0, 26'h0,  1'b1, 3'd2, 1'b1);
      tbl[14] = mk(1'b0, 26'h0,  1'b1, 3'd1, 1'b0);
      tbl[15] = mk(1'b0, 26'h0,  1'b1, 3'd1, 1'b1);
      tbl[16] = mk(1'b0, 26'h0,  1'b1, 3'd0, 1'b0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mm_wr", LINE_W'(mm_wr), LINE_W'(0));
      chk("rst_flush_done", LINE_W'(flush_done), LINE_W'(0));
      chk("rst_empty", LINE_W'(empty), LINE_W'(1));
      chk("rst_full", LINE_W'(full), LINE_W'(0));
      chk("rst_enq_ready", LINE_W'(enq_ready), LINE_W'(1));
      chk("rst_lk_hit", LINE_W'(lk_hit), LINE_W'(0));
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         enq_valid = tbl[i].ev;
         enq_addr  = tbl[i].ea;
         enq_data  = tbl[i].ed;
         mm_ack    = tbl[i].ack;
         @(negedge clk);
         chk($sformatf("tbl%0d_count", i), LINE_W'(count), LINE_W'(tbl[i].cnt));
         chk($sformatf("tbl%0d_mm_wr", i), LINE_W'(mm_wr), LINE_W'(tbl[i].wr));
         chk($sformatf("tbl%0d_full", i), LINE_W'(full), LINE_W'(tbl[i].cnt == 3'd4));
         cyc();
      end
      enq_valid = 1'b0;
      mm_ack    = 1'b0;
      chk("mm0_10", mm0.exists(26'h10) ? mm0[26'h10] : '0, {32{8'hA5}});
      chk("fifth_rejected", LINE_W'(mm0.exists(26'h4)), LINE_W'(0));
      chk("table_writes", LINE_W'(wr_cnt), LINE_W'(5));

      // Coalescing behind an issuing head, then a same-address line while the head is on the bus.
      base = wr_cnt;
      enq(26'h9, pat(26'h9, 8'hC1));
      enq(26'h5, pat(26'h5, 8'hD1));
      enq(26'h7, pat(26'h7, 8'hC7));
      enq(26'h5, pat(26'h5, 8'hD2));
      lk_addr = 26'h5;
      @(negedge clk);
      chk("coal_count", LINE_W'(count), LINE_W'(3));
      chk("coal_lk_d2", lk_data, pat(26'h5, 8'hD2));
      cyc();
      enq(26'h9, pat(26'h9, 8'hC2));
      lk_addr = 26'h9;
      @(negedge clk);
      chk("coal_head_count", LINE_W'(count), LINE_W'(4));
      chk("coal_newest_lk", lk_data, pat(26'h9, 8'hC2));
      cyc();
      drain("coal_drain");
      chk("coal_mm0_5", mm0.exists(26'h5) ? mm0[26'h5] : '0, pat(26'h5, 8'hD2));
      chk("coal_mm0_9", mm0.exists(26'h9) ? mm0[26'h9] : '0, pat(26'h9, 8'hC2));
      chk("coal_writes", LINE_W'(wr_cnt - base), LINE_W'(4));

      // Enqueue and retire in the same cycle, pointers wrapping.
      base = wr_cnt;
      for (int i = 0; i < 4; i++) enq(ADDR_W'(32 + i), pat(ADDR_W'(32 + i), 8'hE0));
      mm_ack = 1'b1;
      cyc();
      mm_ack = 1'b0;
      cyc();
      @(negedge clk);
      chk("sim_pre_count", LINE_W'(count), LINE_W'(3));
      chk("sim_pre_mm_wr", LINE_W'(mm_wr), LINE_W'(1));
      cyc();
      mm_ack    = 1'b1;
      enq_valid = 1'b1;
      enq_addr  = 26'd36;
      enq_data  = pat(26'd36, 8'hE0);
      cyc();
      mm_ack    = 1'b0;
      enq_valid = 1'b0;
      @(negedge clk);
      chk("sim_post_count", LINE_W'(count), LINE_W'(3));
      cyc();
      drain("sim_drain");
      chk("sim_writes", LINE_W'(wr_cnt - base), LINE_W'(5));

      // Flush with ack every third cycle; a second pulse while pending is absorbed.
      for (int i = 0; i < 3; i++) enq(ADDR_W'(48 + i), pat(ADDR_W'(48 + i), 8'hF0));
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      acks = 0; dones = 0; ack3 = -1; done_at = -1;
      for (int n = 0; n < 30; n++) begin
         mm_ack = (n % 3 == 2);
         flush  = (n == 4);
         @(negedge clk);
         if (mm_wr && mm_ack) begin
            acks++;
            if (acks == 3) ack3 = n;
         end
         if (flush_done) begin
            dones++;
            done_at = n;
         end
         cyc();
      end
      mm_ack = 1'b0;
      flush  = 1'b0;
      chk("flush_acks", LINE_W'(acks), LINE_W'(3));
      chk("flush_done_once", LINE_W'(dones), LINE_W'(1));
      chk("flush_done_timing", LINE_W'(done_at - ack3), LINE_W'(1));

      flush = 1'b1;
      @(negedge clk);
      chk("flush_empty_c0", LINE_W'(flush_done), LINE_W'(0));
      cyc();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_empty_c1", LINE_W'(flush_done), LINE_W'(1));
      cyc();
      @(negedge clk);
      chk("flush_empty_c2", LINE_W'(flush_done), LINE_W'(0));
      cyc();

      // Reset while a write is on the bus; later acks must do nothing.
      enq(26'h40, pat(26'h40, 8'h77));
      lk_addr = 26'h40;
      wait_wr("rst_wait_wr");
      base   = wr_cnt;
      reset  = 1'b1;
      mm_ack = 1'b1;
      cyc();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_mm_wr", LINE_W'(mm_wr), LINE_W'(0));
      chk("rst_mid_count", LINE_W'(count), LINE_W'(0));
      chk("rst_mid_lk_hit", LINE_W'(lk_hit), LINE_W'(0));
      repeat (3) cyc();
      @(negedge clk);
      chk("rst_ack_count", LINE_W'(count), LINE_W'(0));
      chk("rst_ack_mm_wr", LINE_W'(mm_wr), LINE_W'(0));
      chk("rst_ack_writes", LINE_W'(wr_cnt - base), LINE_W'(0));
      mm_ack = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1);
   end
endmodule

// File: doc/wb_evict_buffer.md
# wb_evict_buffer

Write-back eviction buffer between the cache controller's RD_EVICT/WR_EVICT path and the main memory (mm0). It accepts dirty 256-bit victim lines from the controller in one cycle and frees the controller to proceed with FILL, then drains the lines to main memory in FIFO order over a request/acknowledge handshake. A line-address lookup port lets FILL read data that is still buffered, so a refill never returns stale main-memory data. A flush input supports INVAL_ALL and reports when every buffered line has been written back.

## Interface
- DEPTH, 4: number of line entries; must be a power of two, at least 2.
- LINE_W, 256: line width in bits (8 x 32-bit words).
- ADDR_W, 26: main-memory line-address width.
- clk  in  1  clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enq_valid  in  1  controller presents a victim line.
- enq_ready  out  1  buffer can accept a line; equal to !full.
- enq_addr  in  ADDR_W  victim line address.
- enq_data  in  LINE_W  victim line data.
- mm_wr  out  1  write request to main memory.
- mm_wr_addr  out  ADDR_W  write line address.
- mm_wr_data  out  LINE_W  write line data.
- mm_ack  in  1  main memory accepted the write in this cycle.
- lk_addr  in  ADDR_W  lookup line address (FILL path).
- lk_hit  out  1  a valid entry matches lk_addr (combinational).
- lk_data  out  LINE_W  data of the newest matching entry; all zeros when there is no hit.
- flush  in  1  single-cycle pulse requesting a full drain.
- flush_done  out  1  single-cycle pulse when a requested drain completes.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

## Operation
- Storage is a circular FIFO of DEPTH entries. Each entry holds valid, addr and data. Write pointer wp and read pointer rp are each $clog2(DEPTH) bits and wrap naturally; count tracks occupancy separately.
- Enqueue happens when enq_valid && enq_ready.
- **Coalescing:** if enq_addr matches a valid entry that is not the head currently being issued (state ISSUE), that entry's data is overwritten in place. count and wp do not change.
- **Normal enqueue:** otherwise the line is written at wp, wp is incremented and count is incremented.
- **Drain FSM:**
  - IDLE: if not empty, go to ISSUE.
  - ISSUE: drive mm_wr=1 with the head entry's addr and data. These values stay stable until mm_ack.
  - On mm_ack: clear the head entry's valid bit, increment rp, decrement count, and go to IDLE.
- **Enqueue and retire in the same cycle:** count is unchanged, both pointers advance, and full stays consistent.
- **Lookup:** lookup compares lk_addr against all valid entries, including the entry being issued. The newest matching entry wins, ordered by distance from rp.
- **Flush:** a flush pulse sets a flush_pend flag. flush_done pulses on the first cycle in which flush_pend is set, the buffer is empty, and the state is IDLE; flush_pend is cleared in that same cycle. A flush while already empty and IDLE gives flush_done on the next cycle. A flush while flush_pend is already set is absorbed.
- Enqueues during flush_pend are still accepted, and flush_done waits for them to drain as well.
- **Reset:**
  - wp, rp and count become 0 and all valid bits are cleared.
  - The state becomes IDLE and flush_pend is cleared.
  - Outputs: mm_wr=0, flush_done=0, empty=1, full=0, enq_ready=1, lk_hit=0.
  - Entry data does not need to be cleared.
- **Reset mid-operation:** all buffered lines are discarded. mm_wr drops at the edge where reset is sampled, and any mm_ack arriving during or after reset while in IDLE is ignored.
- mm_ack received outside ISSUE is ignored.

## Timing
- A line enqueued at edge N is visible to lookup and reflected in count/full from cycle N+1.
- From empty, a line enqueued at edge N reaches ISSUE at edge N+2, so mm_wr is asserted in cycle N+2. This is the minimum enqueue-to-request latency of 2 cycles.
- With mm_ack in the same cycle mm_wr rises, the throughput is one line per 2 cycles, because IDLE always inserts a single cycle with mm_wr low.
- enq_ready is registered-derived (!full) and carries no combinational path from enq_valid.
- lk_hit and lk_data are combinational from lk_addr and the registered entries.
- flush_done is registered and lasts exactly one cycle.

## Test plan
- **Single line:** after reset, enqueue addr 26'h00010 with data 256'hA5..A5, mm_ack tied high.
  - Required: mm_wr high in cycle 2 with addr 26'h00010, count returns to 0 in cycle 3, and mm0 location 26'h00010 equals A5..A5.
- **Full and ordering:** with mm_ack tied low, enqueue 4 distinct addresses 0..3.
  - Required: full=1 and enq_ready=0, and a 5th enq_valid is not accepted.
  - Then release mm_ack. Required: writes retire in order 0,1,2,3 and empty=1 at the end.
- **Coalescing:** with mm_ack low, enqueue addr 5 with data D1, then addr 7, then addr 5 with data D2.
  - Required: count=2 and lk_addr=5 returns D2.
  - After the drain, mm0 location 5 holds D2 and only 2 mm_wr transactions occur.
- **Simultaneous enqueue and retire at full:** with DEPTH entries held, assert mm_ack in the same cycle as an enqueue while full=0 after one retire.
  - Required: count is unchanged and pointers wrap correctly through rp=3 to rp=0.
- **Flush:** with 3 lines buffered and mm_ack asserted every 3rd cycle, pulse flush.
  - Required: flush_done pulses exactly once, one cycle after the 3rd ack.
  - A flush while empty gives flush_done on the next cycle.
- **Reset mid-ISSUE:** hold mm_ack low and assert reset while mm_wr=1.
  - Required: mm_wr=0, count=0 and lk_hit=0 the next cycle.
  - A subsequent mm_ack produces no state change.
